gpio_cmd_master: RTL



---
 rtl/gpio_cmd_master.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gpio_cmd_master.sv
// gpio_cmd_master: hardware command initiator for the 32-bit GPO/GPI register file.
// Drives {code, enable, data} on o_gpo with a setup / strobe / release sequence
// and captures the GPI read-back word once the release window has elapsed.
// Optional build macro GPIO_CMD_FIFO_EN adds a FIFO_DEPTH-entry command queue
// in front of the sequencer (one extra cycle from handshake to o_gpo).
module gpio_cmd_master #(
  parameter int NB_GPIOS   = 32,
  parameter int NB_CMD     = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int RSP_CYC    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       i_rstn,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [NB_CMD-1:0]          i_cmd_code,
  input  logic [NB_GPIOS-NB_CMD-2:0] i_cmd_data,
  output logic                       o_rsp_valid,
  output logic [NB_GPIOS-1:0]        o_rsp_data,
  output logic                       o_busy,
  output logic [NB_GPIOS-1:0]        o_gpo,
  input  logic [NB_GPIOS-1:0]        i_gpi
);

  localparam int DW     = NB_GPIOS - NB_CMD - 1;   // payload width
  localparam int EN_BIT = DW;                      // enable bit sits just above the payload
  localparam int CMDW   = NB_CMD + DW;             // stored command word {code, data}
  localparam int MAX_AB = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_C  = (MAX_AB > RSP_CYC) ? MAX_AB : RSP_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] RSP_LD    = CW'(RSP_CYC - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // Elaboration-time sanity checks on the timing and queue parameters.
  if (SETUP_CYC < 1 || STROBE_CYC < 1 || RSP_CYC < 1) begin : g_bad_cyc
    $error("gpio_cmd_master: SETUP_CYC, STROBE_CYC and RSP_CYC must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("gpio_cmd_master: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [1:0]      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            start;
  logic [CMDW-1:0] start_word;
  logic            ld, en_set, en_clr, cap;
  logic            busy_nxt, ready_nxt;

`ifdef GPIO_CMD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [CMDW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt, fifo_cnt_nxt;
  logic            push, pop;

  assign push       = i_cmd_valid && o_cmd_ready;
  assign pop        = start;
  assign start      = (state == S_IDLE) && (fifo_cnt != '0);
  assign start_word = fifo_mem[rd_ptr];

  // Queue occupancy after this edge; a simultaneous push and pop keeps the count.
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop) begin
      fifo_cnt_nxt = fifo_cnt + (AW+1)'(1);
    end else if (!push && pop) begin
      fifo_cnt_nxt = fifo_cnt - (AW+1)'(1);
    end
  end

  // Queue pointers and occupancy; reset empties the queue.
  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt_nxt;
    end
  end

  // Queue storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {i_cmd_code, i_cmd_data};
  end

  assign busy_nxt  = (state_nxt != S_IDLE) || (fifo_cnt_nxt != '0);
  assign ready_nxt = (fifo_cnt_nxt != FULL_CNT);
`else
  assign start      = (state == S_IDLE) && i_cmd_valid && o_cmd_ready;
  assign start_word = {i_cmd_code, i_cmd_data};
  assign busy_nxt   = (state_nxt != S_IDLE);
  assign ready_nxt  = (state_nxt == S_IDLE);
`endif

  // Sequencer next state: each phase counts down its length and hands over at zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld        = 1'b0;
    en_set    = 1'b0;
    en_clr    = 1'b0;
    cap       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ld        = 1'b1;
          state_nxt = S_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          en_set    = 1'b1;
          state_nxt = S_STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          en_clr    = 1'b1;
          state_nxt = S_RELEASE;
          cnt_nxt   = RSP_LD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_RELEASE: begin
        if (cnt == '0) begin
          cap       = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered sequencer state, GPO word and response outputs.
  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      o_gpo       <= '0;
      o_rsp_data  <= '0;
      o_rsp_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_cmd_ready <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_busy      <= busy_nxt;
      o_cmd_ready <= ready_nxt;
      o_rsp_valid <= cap;
      if (cap) o_rsp_data <= i_gpi;
      if (ld) begin
        o_gpo <= {start_word[CMDW-1 -: NB_CMD], 1'b0, start_word[DW-1:0]};
      end else if (en_set) begin
        o_gpo[EN_BIT] <= 1'b1;
      end else if (en_clr) begin
        o_gpo[EN_BIT] <= 1'b0;
      end
    end
  end

endmodule
